// File: rtl/risc_sequencer.sv
// ---------------------------------------------------------------------------
// RiscSequencer -- multi-cycle control sequencer for a small 8-opcode RISC.
//
// Walks each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB)
// and decodes the datapath load enables and mux selects from the current
// state and an opcode register latched in DECODE.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   run       permits a new fetch (sampled in FETCH with nothing outstanding)
//   opcode    instruction opcode field, valid from the cycle after ir_we
//   eq_out    ALU equality result, valid in EXEC
//   mem_ack   unified memory acknowledge (one-cycle pulse)
//   mem_req   memory request, held until mem_ack
//   mem_we    memory write strobe (SW only)
//   addr_sel  0 = PC addresses memory, 1 = ALU result addresses memory
//   ir_we, mdr_we, pc_we, reg_we   datapath load enables
//   alu_op    00 ADD, 01 NAND, 10 PASS1, 11 EQ
//   pc_sel    00 PC+1, 01 PC+1+imm, 10 ALU result
//   wb_sel    00 ALU result, 01 MDR, 10 PC
//   state     current state code for debug
//   retire    one-cycle pulse on instruction completion
//   icount    wrapping count of retired instructions
// ---------------------------------------------------------------------------
module risc_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [2:0]  opcode,
   input  logic        eq_out,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic        addr_sel,
   output logic        ir_we,
   output logic        mdr_we,
   output logic        pc_we,
   output logic        reg_we,
   output logic [1:0]  alu_op,
   output logic [1:0]  pc_sel,
   output logic [1:0]  wb_sel,
   output logic [2:0]  state,
   output logic        retire,
   output logic [15:0] icount
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_LUI  = 3'b011;
   localparam logic [2:0] OP_LW   = 3'b100;
   localparam logic [2:0] OP_SW   = 3'b101;
   localparam logic [2:0] OP_BEQ  = 3'b110;
   localparam logic [2:0] OP_JALR = 3'b111;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_NAND = 2'b01;
   localparam logic [1:0] ALU_PASS = 2'b10;
   localparam logic [1:0] ALU_EQ   = 2'b11;

   state_t      r_state;
   state_t      w_nextState;
   logic        r_fetchPending;
   logic        w_nextPending;
   logic [2:0]  r_op;
   logic [15:0] r_icount;
   logic [1:0]  w_aluOp;

   assign state  = r_state;
   assign icount = r_icount;

   // State register. Reset lands in FETCH with no fetch outstanding, which
   // also drops mem_req immediately because mem_req is decoded from these.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_FETCH;
         r_fetchPending <= 1'b0;
      end else begin
         r_state        <= w_nextState;
         r_fetchPending <= w_nextPending;
      end
   end

   // The opcode is captured once in DECODE so that later states never see
   // the live opcode input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op <= 3'd0;
      end else if (r_state == S_DECODE) begin
         r_op <= opcode;
      end
   end

   // Retired-instruction counter; plain 16-bit add so it wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_icount <= 16'd0;
      end else if (retire) begin
         r_icount <= r_icount + 16'd1;
      end
   end

   // ALU function for the latched opcode, shared by EXEC and WB so WB keeps
   // the operation EXEC used.
   always_comb begin
      w_aluOp = ALU_ADD;
      case (r_op)
         OP_ADD, OP_ADDI: w_aluOp = ALU_ADD;
         OP_NAND:         w_aluOp = ALU_NAND;
         OP_LUI:          w_aluOp = ALU_PASS;
         OP_LW, OP_SW:    w_aluOp = ALU_ADD;
         OP_BEQ:          w_aluOp = ALU_EQ;
         OP_JALR:         w_aluOp = ALU_PASS;
         default:         w_aluOp = ALU_ADD;
      endcase
   end

   // Next-state and output decode. A fetch request becomes outstanding on
   // the edge where run is seen high in FETCH, and stays outstanding until
   // it is acknowledged regardless of run. mem_ack only has an effect while
   // a request is actually being presented.
   always_comb begin
      w_nextState   = r_state;
      w_nextPending = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      addr_sel      = 1'b0;
      ir_we         = 1'b0;
      mdr_we        = 1'b0;
      pc_we         = 1'b0;
      reg_we        = 1'b0;
      alu_op        = ALU_ADD;
      pc_sel        = 2'b00;
      wb_sel        = 2'b00;
      retire        = 1'b0;

      case (r_state)
         S_FETCH: begin
            if (r_fetchPending) begin
               mem_req = 1'b1;
               if (mem_ack) begin
                  ir_we       = 1'b1;
                  pc_we       = 1'b1;
                  w_nextState = S_DECODE;
               end else begin
                  w_nextPending = 1'b1;
               end
            end else begin
               w_nextPending = run;
            end
         end

         S_DECODE: begin
            w_nextState = S_EXEC;
         end

         S_EXEC: begin
            alu_op = w_aluOp;
            case (r_op)
               OP_LW, OP_SW: begin
                  w_nextState = S_MEM;
               end
               OP_BEQ: begin
                  pc_we       = eq_out;
                  pc_sel      = 2'b01;
                  retire      = 1'b1;
                  w_nextState = S_FETCH;
               end
               OP_JALR: begin
                  reg_we      = 1'b1;
                  wb_sel      = 2'b10;
                  pc_we       = 1'b1;
                  pc_sel      = 2'b10;
                  retire      = 1'b1;
                  w_nextState = S_FETCH;
               end
               default: begin
                  w_nextState = S_WB;
               end
            endcase
         end

         S_MEM: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            alu_op   = ALU_ADD;
            mem_we   = (r_op == OP_SW);
            if (mem_ack) begin
               if (r_op == OP_SW) begin
                  retire      = 1'b1;
                  w_nextState = S_FETCH;
               end else begin
                  mdr_we      = 1'b1;
                  w_nextState = S_WB;
               end
            end
         end

         S_WB: begin
            reg_we      = 1'b1;
            wb_sel      = (r_op == OP_LW) ? 2'b01 : 2'b00;
            alu_op      = w_aluOp;
            retire      = 1'b1;
            w_nextState = S_FETCH;
         end

         default: begin
            w_nextState = S_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_risc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_risc_sequencer -- self-checking bench for risc_sequencer.
//
// Each instruction is expanded, from the architectural cycle rules, into a
// list of per-cycle records holding the inputs to drive and every output
// expected in that cycle. One process drives a record just after each rising
// edge and compares all outputs on the following falling edge. Fetch-to-
// retire latency is additionally measured on the DUT and compared against
// the literal latency table plus the inserted ack wait cycles.
// ---------------------------------------------------------------------------
module tb_risc_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic [2:0]  opcode = 3'd0;
   logic        eq_out = 1'b0;
   logic        mem_ack = 1'b0;
   logic        mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, reg_we;
   logic [1:0]  alu_op, pc_sel, wb_sel;
   logic [2:0]  state;
   logic        retire;
   logic [15:0] icount;

   risc_sequencer dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .eq_out(eq_out),
      .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
      .addr_sel(addr_sel), .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we),
      .reg_we(reg_we), .alu_op(alu_op), .pc_sel(pc_sel), .wb_sel(wb_sel),
      .state(state), .retire(retire), .icount(icount)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        memReq, memWe, addrSel, irWe, mdrWe, pcWe, regWe;
      logic [1:0]  aluOp, pcSel, wbSel;
      logic [2:0]  st;
      logic        retire;
      logic [15:0] icnt;
   } out_t;

   typedef struct {
      logic       rst, run;
      logic [2:0] opc;
      logic       eq, ack, preload;
      out_t       e;
      int         expLat;
   } vec_t;

   vec_t        vecs[$];
   vec_t        cur;
   logic [15:0] mIcount = 16'd0;
   int          vectors = 0;
   int          miscompares = 0;

   // ALU operation each opcode uses.
   function automatic logic [1:0] aluFor(input logic [2:0] op);
      case (op)
         3'd2:    return 2'b01;
         3'd3:    return 2'b10;
         3'd6:    return 2'b11;
         3'd7:    return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   // Fetch-request-to-retire latency with single-cycle acks.
   function automatic int baseLat(input logic [2:0] op);
      case (op)
         3'd4:       return 5;
         3'd6, 3'd7: return 3;
         default:    return 4;
      endcase
   endfunction

   task automatic newCycle(input logic [2:0] garbage);
      cur.rst     = 1'b0;
      cur.run     = 1'b0;
      cur.opc     = garbage;
      cur.eq      = 1'b0;
      cur.ack     = 1'b0;
      cur.preload = 1'b0;
      cur.e       = '0;
      cur.expLat  = 0;
   endtask

   task automatic pushCycle();
      if (cur.rst) mIcount = 16'd0;
      if (cur.preload) mIcount = 16'hFFFF;
      cur.e.icnt = mIcount;
      if (cur.e.retire) mIcount = mIcount + 16'd1;
      vecs.push_back(cur);
   endtask

   task automatic addIdle(input int n, input logic ack);
      for (int k = 0; k < n; k++) begin
         newCycle(3'd5);
         cur.ack = ack;
         pushCycle();
      end
   endtask

   // Expand one instruction: fw/mw are extra wait cycles before the fetch
   // and data acks; abortMem resets the block during the first MEM cycle.
   task automatic addInstr(input logic [2:0] op, input logic eq,
                           input int fw, input int mw, input logic abortMem);
      logic [2:0] g;
      int lat;
      g   = ~op;
      lat = baseLat(op) + fw + ((op == 3'd4 || op == 3'd5) ? mw : 0);

      newCycle(g); cur.run = 1'b1; pushCycle();
      for (int k = 0; k < fw; k++) begin
         newCycle(g); cur.e.memReq = 1'b1; pushCycle();
      end
      newCycle(g); cur.ack = 1'b1;
      cur.e.memReq = 1'b1; cur.e.irWe = 1'b1; cur.e.pcWe = 1'b1;
      pushCycle();

      // A stray ack while decoding must be ignored.
      newCycle(op); cur.ack = 1'b1; cur.e.st = 3'd1; pushCycle();

      newCycle(g); cur.eq = eq; cur.e.st = 3'd2; cur.e.aluOp = aluFor(op);
      if (op == 3'd6) begin
         cur.e.pcSel = 2'b01; cur.e.pcWe = eq; cur.e.retire = 1'b1;
         cur.expLat = lat;
      end else if (op == 3'd7) begin
         cur.e.regWe = 1'b1; cur.e.wbSel = 2'b10; cur.e.pcWe = 1'b1;
         cur.e.pcSel = 2'b10; cur.e.retire = 1'b1; cur.expLat = lat;
      end
      pushCycle();
      if (op == 3'd6 || op == 3'd7) return;

      if (op == 3'd4 || op == 3'd5) begin
         for (int k = 0; k <= mw; k++) begin
            newCycle(g); cur.e.st = 3'd3; cur.e.memReq = 1'b1;
            cur.e.addrSel = 1'b1; cur.e.memWe = (op == 3'd5);
            if (k == mw) begin
               cur.ack = 1'b1;
               if (op == 3'd4) cur.e.mdrWe = 1'b1;
               else begin cur.e.retire = 1'b1; cur.expLat = lat; end
            end
            pushCycle();
            if (abortMem) begin
               newCycle(g); cur.rst = 1'b1; cur.run = 1'b1; pushCycle();
               newCycle(g); cur.ack = 1'b1; pushCycle();
               return;
            end
         end
         if (op == 3'd5) return;
      end

      newCycle(g); cur.e.st = 3'd4; cur.e.regWe = 1'b1;
      cur.e.wbSel = (op == 3'd4) ? 2'b01 : 2'b00; cur.e.aluOp = aluFor(op);
      cur.e.retire = 1'b1; cur.expLat = lat;
      pushCycle();
   endtask

   task automatic applyStimulus(input vec_t v);
      rst     = v.rst;
      run     = v.run;
      opcode  = v.opc;
      eq_out  = v.eq;
      mem_ack = v.ack;
      if (v.preload) force dut.r_icount = 16'hFFFF;
   endtask

   logic inReq = 1'b0;
   int   reqStart = 0;

   task automatic checkOutput(input vec_t v, input int idx);
      out_t act;
      int   measured;
      act = {mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, reg_we,
             alu_op, pc_sel, wb_sel, state, retire, icount};
      vectors++;
      if (act !== v.e) begin
         miscompares++;
         $display("[TB] FAIL vec%0d outputs: got %h expected %h", idx, act, v.e);
      end
      if (rst) inReq = 1'b0;
      if (!inReq && mem_req && state == 3'd0) begin
         inReq    = 1'b1;
         reqStart = idx;
      end
      if (v.expLat != 0) begin
         measured = (inReq && retire) ? idx - reqStart + 1 : -1;
         vectors++;
         if (measured != v.expLat) begin
            miscompares++;
            $display("[TB] FAIL vec%0d latency: got %0d expected %0d",
                     idx, measured, v.expLat);
         end
      end
      if (retire) inReq = 1'b0;
   endtask

   initial begin
      logic released;
      // Reset, then idle with a stray ack while nothing is requested.
      newCycle(3'd0); cur.rst = 1'b1; pushCycle();
      newCycle(3'd0); cur.rst = 1'b1; pushCycle();
      addIdle(1, 1'b0);
      addIdle(1, 1'b1);
      addInstr(3'd0, 1'b0, 0, 0, 1'b0);   // ADD
      addInstr(3'd1, 1'b0, 2, 0, 1'b0);   // ADDI, slow fetch, run low
      addInstr(3'd2, 1'b0, 0, 0, 1'b0);   // NAND
      addInstr(3'd3, 1'b0, 1, 0, 1'b0);   // LUI
      addInstr(3'd4, 1'b0, 0, 3, 1'b0);   // LW, 3-cycle data delay
      addInstr(3'd5, 1'b0, 0, 0, 1'b0);   // SW
      addInstr(3'd5, 1'b0, 0, 2, 1'b0);   // SW, slow data ack
      addInstr(3'd6, 1'b1, 0, 0, 1'b0);   // BEQ taken
      addInstr(3'd6, 1'b0, 0, 0, 1'b0);   // BEQ not taken
      addInstr(3'd7, 1'b0, 0, 0, 1'b0);   // JALR
      addIdle(3, 1'b0);
      addInstr(3'd5, 1'b0, 0, 1, 1'b1);   // SW aborted by reset in MEM
      addInstr(3'd0, 1'b0, 0, 0, 1'b0);   // ADD after reset
      newCycle(3'd0); cur.preload = 1'b1; pushCycle();
      addInstr(3'd6, 1'b1, 0, 0, 1'b0);   // retire that wraps icount
      addIdle(3, 1'b0);
      addInstr(3'd0, 1'b0, 0, 0, 1'b0);

      // Spot checks pinning the latency table itself.
      vectors++;
      if (baseLat(3'd0) != 4 || baseLat(3'd4) != 5 || baseLat(3'd5) != 4 ||
          baseLat(3'd6) != 3 || baseLat(3'd7) != 3) begin
         miscompares++;
         $display("[TB] FAIL latency table: got %0d/%0d/%0d/%0d/%0d expected 4/5/4/3/3",
                  baseLat(3'd0), baseLat(3'd4), baseLat(3'd5), baseLat(3'd6), baseLat(3'd7));
      end

      released = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk);
         #1;
         if (!released) begin
            release dut.r_icount;
            released = 1'b1;
         end
         applyStimulus(vecs[i]);
         if (vecs[i].preload) released = 1'b0;
         @(negedge clk);
         checkOutput(vecs[i], i);
      end
      if (!released) release dut.r_icount;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/risc_sequencer.md
RISC_SEQUENCER -- requirements
Module: risc_sequencer

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 run  input  1  permits starting a new instruction fetch; sampled only in FETCH when no request is outstanding.
REQ-005 opcode  input  3  opcode field from the instruction register; valid from the cycle after ir_we.
REQ-006 eq_out  input  1  ALU equality result; valid in EXEC.
REQ-007 mem_ack  input  1  unified memory acknowledge; one-cycle pulse completing the current request.
REQ-008 mem_req  output  1  memory request; held high until mem_ack.
REQ-009 mem_we  output  1  memory write strobe; high only with mem_req for SW.
REQ-010 addr_sel  output  1  0 = PC drives the memory address, 1 = ALU result drives it.
REQ-011 ir_we, mdr_we, pc_we, reg_we  output  1 each  load enables for IR, MDR, PC and the register file.
REQ-012 alu_op  output  2  00 ADD, 01 NAND, 10 PASS1, 11 EQ.
REQ-013 pc_sel  output  2  00 PC+1, 01 PC+1+imm (branch), 10 ALU result (JALR).
REQ-014 wb_sel  output  2  00 ALU result, 01 MDR, 10 PC.
REQ-015 state  output  3  current state code, for debug.
REQ-016 retire  output  1  one-cycle pulse marking instruction completion.
REQ-017 icount  output  16  count of retired instructions.

Function
REQ-018 States and codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-019 All outputs SHALL be Moore/Mealy-decoded from the state and the latched opcode; there is no combinational path from opcode to outputs.
REQ-020 FETCH, entry and idle behaviour:
- when run=1, assert mem_req with addr_sel=0 and mem_we=0;
- while run=0 and no request is outstanding, stay in FETCH with mem_req=0.
REQ-021 FETCH, on mem_ack: pulse ir_we=1 and pc_we=1 with pc_sel=00, then go to DECODE.
REQ-022 An outstanding fetch SHALL stay asserted even if run falls.
REQ-023 DECODE SHALL latch opcode into an internal op register, assert no enables, and always go to EXEC.
REQ-024 EXEC by op:
- ADD/ADDI (000/001): alu_op=00, go to WB.
- NAND (010): alu_op=01, go to WB.
- LUI (011): alu_op=10, go to WB.
- LW/SW (100/101): alu_op=00, go to MEM.
- BEQ (110): alu_op=11; pc_we=eq_out with pc_sel=01; retire; go to FETCH.
- JALR (111): alu_op=10, reg_we=1, wb_sel=10, pc_we=1, pc_sel=10, retire, go to FETCH.
REQ-025 MEM:
- mem_req=1, addr_sel=1, alu_op=00; mem_we=1 for SW only.
- On mem_ack for LW: mdr_we=1, go to WB.
- On mem_ack for SW: retire, go to FETCH.
- With no mem_ack, hold all MEM outputs stable.
REQ-026 WB: reg_we=1, wb_sel=01 for LW and 00 otherwise, keep the EXEC alu_op, retire, go to FETCH.
REQ-027 With single-cycle ack, latencies from fetch request to retire SHALL be:
- ALU ops and LUI: 4 cycles.
- LW: 5 cycles.
- SW: 4 cycles.
- BEQ and JALR: 3 cycles.
Each extra wait cycle on an ack adds 1.
REQ-028 icount SHALL increment by 1 on each retire, wrap from 0xFFFF to 0x0000, and not saturate.
REQ-029 A mem_ack outside FETCH or MEM, or while mem_req=0, SHALL be ignored.
REQ-030 pc_we and reg_we SHALL never both be asserted in one cycle except in JALR EXEC.

Reset
REQ-031 While rst=1, the block SHALL immediately force FETCH and drive all enables, mem_req, mem_we, retire=0, icount=0, and alu_op/pc_sel/wb_sel/addr_sel=0.
REQ-032 Reset mid-request SHALL drop mem_req at once; a late mem_ack after reset release SHALL be ignored per REQ-029.
REQ-033 After rst falls, the first mem_req SHALL rise on the first clock edge at which run=1.

Verification
REQ-034 ADD, ack on the first request cycle: ir_we+pc_we at cycle 1 -> reg_we with wb_sel=00, retire at cycle 4, icount=1.
REQ-035 LW with a 3-cycle data ack delay: mem_req, addr_sel=1, mem_we=0 held 3 cycles -> mdr_we on ack -> WB with wb_sel=01 -> retire.
REQ-036 BEQ:
- eq_out=1 -> pc_we=1, pc_sel=01 in EXEC.
- eq_out=0 -> pc_we=0.
- Both cases return to FETCH next cycle.
REQ-037 JALR: a single EXEC cycle with reg_we=1, wb_sel=10, pc_we=1, pc_sel=10, alu_op=10, retire=1.
REQ-038 rst asserted in MEM of SW with mem_req high -> mem_req=0 in the same cycle, state=0, icount=0; mem_ack one cycle after release -> no ir_we.
REQ-039 Preload icount to 0xFFFF via 65535 retires, then one more retire -> icount=0x0000; run=0 between instructions -> mem_req stays 0.
